// File: rtl/draw_seq_pkg.sv
// draw_seq_pkg: shared types and constants for the draw sequencer
package draw_seq_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_WAIT_TICK,
    S_DRAW,
    S_DEAD_CLEAR,
    S_STOP_CLEAR,
    S_DEAD
  } state_t;
  // PRE: start low before the first draw; START: start high, stale done ignored;
  // WAIT: start high, done sampled; GAP: start low for one cycle after done
  typedef enum logic [1:0] {
    P_PRE,
    P_START,
    P_WAIT,
    P_GAP
  } phase_t;
  typedef logic [3:0] bcd_digit_t;
  localparam logic [7:0] BCD_MAX = 8'h99;
endpackage

// File: rtl/bcd_counter_2d.sv
// bcd_counter_2d: two-digit BCD counter adding 0..2^INC_W-1 per cycle, saturating at 99
module bcd_counter_2d
  import draw_seq_pkg::*;
#(
  parameter int INC_W = 5
) (
  input  logic             i_clock,
  input  logic             i_resetn,
  input  logic [INC_W-1:0] i_inc,
  input  logic             i_clr,
  output logic [7:0]       o_bcd
);
  logic [7:0] r_bcd;
  logic [7:0] w_sum;
  bcd_digit_t w_tens;
  bcd_digit_t w_ones;
  assign w_sum  = 8'(r_bcd[7:4]) * 8'd10 + 8'(r_bcd[3:0]) + 8'(i_inc);
  assign w_tens = 4'(w_sum / 8'd10);
  assign w_ones = 4'(w_sum % 8'd10);
  assign o_bcd  = r_bcd;
  // accumulate in binary, saturate, and store back as BCD; clear wins over increment
  always_ff @(posedge i_clock or negedge i_resetn)
    if (!i_resetn) r_bcd <= '0;
    else r_bcd <= i_clr ? '0 : (w_sum > 8'd99) ? BCD_MAX : {w_tens, w_ones};
endmodule

// File: rtl/draw_sequencer.sv
// draw_sequencer: game FSM multiplexing N_SHAPES drawers onto one VGA port; DRAW_SEQ_GOD_MODE_EN lets god_mode mask spike_hit
module draw_sequencer
  import draw_seq_pkg::*;
#(
  parameter int N_SHAPES = 16,
  parameter int COORD_W  = 11,
  parameter int COLOUR_W = 3
) (
  input  logic                         i_clock,
  input  logic                         i_resetn,
  input  logic                         i_start_switch,
  input  logic                         i_spike_hit,
  input  logic                         i_god_mode,
  input  logic                         i_frame_tick,
  input  logic [N_SHAPES-1:0]          i_shape_active,
  input  logic [N_SHAPES-1:0]          i_shape_gone,
  input  logic [N_SHAPES-1:0]          i_draw_done,
  input  logic [N_SHAPES*COORD_W-1:0]  i_shape_x,
  input  logic [N_SHAPES*COORD_W-1:0]  i_shape_y,
  input  logic [N_SHAPES*COLOUR_W-1:0] i_shape_colour,
  output logic [N_SHAPES-1:0]          o_draw_start,
  output logic                         o_shape_reset,
  output logic                         o_vga_enable,
  output logic [COORD_W-1:0]           o_vga_x,
  output logic [COORD_W-1:0]           o_vga_y,
  output logic [COLOUR_W-1:0]          o_vga_colour,
  output logic [7:0]                   o_score_bcd,
  output logic [7:0]                   o_attempts_bcd,
  output logic                         o_frame_overrun
);
  localparam int IDX_W = (N_SHAPES > 1) ? $clog2(N_SHAPES) : 1;
  localparam int INC_W = $clog2(N_SHAPES + 1);
  state_t r_state, w_state_n;
  phase_t r_phase, w_phase_n;
  logic [IDX_W-1:0] r_idx, w_idx_n;
  logic r_overrun;
  logic w_spike, w_death, w_start_game, w_advance, w_run, w_drawing, w_parked, w_last, w_skip, w_overrun_set;
  logic [INC_W-1:0] w_gone_cnt, w_death_inc;
`ifdef DRAW_SEQ_GOD_MODE_EN
  assign w_spike = i_spike_hit & ~i_god_mode;
`else
  logic w_unused_god;
  assign w_unused_god = i_god_mode;
  assign w_spike      = i_spike_hit;
`endif
  assign w_run         = r_state inside {S_CLEAR, S_WAIT_TICK, S_DRAW};
  assign w_drawing     = r_state inside {S_CLEAR, S_DRAW, S_DEAD_CLEAR, S_STOP_CLEAR};
  assign w_parked      = r_state inside {S_IDLE, S_DEAD};
  assign w_last        = r_idx == IDX_W'(N_SHAPES - 1);
  assign w_skip        = r_state == S_DRAW && r_idx != '0 && !i_shape_active[r_idx];
  assign w_overrun_set = i_frame_tick && (r_state == S_DRAW || r_state == S_CLEAR);
  assign o_draw_start  = (w_drawing && (r_phase == P_START || r_phase == P_WAIT) && !w_skip)
                         ? (N_SHAPES'(1) << r_idx) : '0;
  assign o_vga_enable    = !w_parked;
  assign o_shape_reset   = w_parked;
  assign o_frame_overrun = r_overrun;
  assign o_vga_x      = i_shape_x[r_idx*COORD_W +: COORD_W];
  assign o_vga_y      = i_shape_y[r_idx*COORD_W +: COORD_W];
  assign o_vga_colour = i_shape_colour[r_idx*COLOUR_W +: COLOUR_W];
  assign w_gone_cnt   = INC_W'($countones(i_shape_gone));
  assign w_death_inc  = INC_W'(w_death);
  // next state: per-shape handshake phases, then death/stop overrides with death taking priority
  always_comb begin
    w_state_n    = r_state;
    w_phase_n    = r_phase;
    w_idx_n      = r_idx;
    w_death      = 1'b0;
    w_start_game = 1'b0;
    w_advance    = 1'b0;
    case (r_state)
      S_IDLE: if (i_start_switch) begin
        w_state_n    = S_CLEAR;
        w_phase_n    = P_START;
        w_idx_n      = '0;
        w_start_game = 1'b1;
      end
      S_DEAD: if (!i_start_switch) w_state_n = S_IDLE;
      S_WAIT_TICK: if (i_frame_tick) begin
        w_state_n = S_DRAW;
        w_phase_n = P_START;
        w_idx_n   = '0;
      end
      default: case (r_phase)
        P_PRE:   w_phase_n = P_START;
        P_START: if (w_skip) w_advance = 1'b1; else w_phase_n = P_WAIT;
        P_WAIT:  if (i_draw_done[r_idx]) w_phase_n = P_GAP;
        default: w_advance = 1'b1;
      endcase
    endcase
    if (w_advance) begin
      w_phase_n = P_START;
      w_idx_n   = (r_state == S_DRAW && !w_last) ? r_idx + 1'b1 : '0;
      w_state_n = (r_state == S_DRAW && !w_last) ? S_DRAW :
                  (r_state == S_DEAD_CLEAR) ? S_DEAD :
                  (r_state == S_STOP_CLEAR) ? S_IDLE : S_WAIT_TICK;
    end
    if (w_run && (w_spike || !i_start_switch)) begin
      w_death   = w_spike;
      w_state_n = w_spike ? S_DEAD_CLEAR : S_STOP_CLEAR;
      w_phase_n = P_PRE;
      w_idx_n   = '0;
    end
  end
  // state, index, phase and the sticky overrun flag
  always_ff @(posedge i_clock or negedge i_resetn)
    if (!i_resetn) begin
      r_state   <= S_IDLE;
      r_phase   <= P_START;
      r_idx     <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_phase   <= w_phase_n;
      r_idx     <= w_idx_n;
      r_overrun <= w_start_game ? 1'b0 : (r_overrun | w_overrun_set);
    end
  bcd_counter_2d #(.INC_W(INC_W)) u_score (
    .i_clock (i_clock),
    .i_resetn(i_resetn),
    .i_inc   (w_gone_cnt),
    .i_clr   (w_start_game),
    .o_bcd   (o_score_bcd)
  );
  bcd_counter_2d #(.INC_W(INC_W)) u_attempts (
    .i_clock (i_clock),
    .i_resetn(i_resetn),
    .i_inc   (w_death_inc),
    .i_clr   (1'b0),
    .o_bcd   (o_attempts_bcd)
  );
endmodule
